// File: rtl/lsu_pkg.sv
// Shared encodings, state type and request validation for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LD_WAIT = 2'd1,
      ST_RMW     = 2'd2,
      ST_RESP    = 2'd3
   } lsu_state_e;

   // A request is rejected for an illegal size, a misaligned access or an
   // address past the end of the memory.
   function automatic logic lsu_req_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned words);
      logic [31:0] limit;
      limit = words << 2;
      return (size == SZ_ILL)
          || ((size == SZ_HALF) && addr[0])
          || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
          || (addr >= limit);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extraction with extension, store merge.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] ld_data_o,
   input  logic [31:0] st_old_i,
   input  logic [15:0] st_new_i,
   output logic [31:0] st_word_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Load path: select the little-endian lane, then zero/sign extend it
   always_comb begin
      case (addr_lo_i)
         2'd0:    ld_byte = ld_word_i[7:0];
         2'd1:    ld_byte = ld_word_i[15:8];
         2'd2:    ld_byte = ld_word_i[23:16];
         default: ld_byte = ld_word_i[31:24];
      endcase
      ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
      case (size_i)
         SZ_BYTE: ld_data_o = {{24{signed_i & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data_o = {{16{signed_i & ld_half[15]}}, ld_half};
         default: ld_data_o = ld_word_i;
      endcase
   end

   // Store path: replace only the addressed lane of the old word
   always_comb begin
      st_word_o = st_old_i;
      case (size_i)
         SZ_BYTE: begin
            case (addr_lo_i)
               2'd0:    st_word_o = {st_old_i[31:8], st_new_i[7:0]};
               2'd1:    st_word_o = {st_old_i[31:16], st_new_i[7:0], st_old_i[7:0]};
               2'd2:    st_word_o = {st_old_i[31:24], st_new_i[7:0], st_old_i[15:0]};
               default: st_word_o = {st_new_i[7:0], st_old_i[23:0]};
            endcase
         end
         SZ_HALF: begin
            st_word_o = addr_lo_i[1] ? {st_new_i, st_old_i[15:0]}
                                     : {st_old_i[31:16], st_new_i};
         end
         default: st_word_o = st_old_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a 1-cycle-latency single-port data RAM.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int data_width      = 32,
   parameter int data_words      = 512,
   parameter int data_addr_width = $clog2(data_words)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [1:0]                 req_size,
   input  logic                       req_signed,
   input  logic [31:0]                req_addr,
   input  logic [data_width-1:0]      req_wdata,
   output logic                       resp_valid,
   output logic [data_width-1:0]      resp_rdata,
   output logic                       resp_err,
   output logic                       mem_we,
   output logic [data_addr_width-1:0] mem_addr,
   output logic [data_width-1:0]      mem_wd,
   input  logic [data_width-1:0]      mem_rd
);

   lsu_state_e                 state_q, state_d;
   logic [data_addr_width-1:0] addr_q;
   logic [1:0]                 lo_q;
   logic [1:0]                 size_q;
   logic                       signed_q;
   logic [15:0]                wdata_q;
   logic [data_width-1:0]      rdata_q, rdata_d;
   logic                       err_q, err_d;
   logic                       accept;
   logic                       req_err;
   logic [31:0]                ld_data;
   logic [31:0]                st_word;

   assign req_ready  = rst_n & (state_q == ST_IDLE);
   assign accept     = req_valid & req_ready;
   assign req_err    = lsu_req_err(req_size, req_addr, $unsigned(data_words));
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   lsu_lane_align u_align (
      .ld_word_i (mem_rd),
      .addr_lo_i (lo_q),
      .size_i    (size_q),
      .signed_i  (signed_q),
      .ld_data_o (ld_data),
      .st_old_i  (mem_rd),
      .st_new_i  (wdata_q),
      .st_word_o (st_word)
   );

   // Next state and the response payload latched on entry to RESP
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_d = ST_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (!req_we) begin
                  state_d = ST_LD_WAIT;
               end else if (req_size == SZ_WORD) begin
                  state_d = ST_RESP;
                  rdata_d = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_RMW;
               end
            end
         end
         ST_LD_WAIT: begin
            state_d = ST_RESP;
            rdata_d = ld_data;
            err_d   = 1'b0;
         end
         ST_RMW: begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory port: live request address/data in IDLE, held address afterwards;
   // everything forced quiet while reset is asserted so no write can slip out
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE: begin
               mem_addr = req_addr[data_addr_width+1:2];
               mem_wd   = req_wdata;
               mem_we   = req_valid & req_we & (req_size == SZ_WORD) & ~req_err;
            end
            ST_RMW: begin
               mem_addr = addr_q;
               mem_wd   = st_word;
               mem_we   = 1'b1;
            end
            default: mem_addr = addr_q;
         endcase
      end
   end

   // FSM state and held response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Capture the request fields at accept for use in later cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         lo_q     <= 2'b00;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         wdata_q  <= '0;
      end else if (accept) begin
         addr_q   <= req_addr[data_addr_width+1:2];
         lo_q     <= req_addr[1:0];
         size_q   <= req_size;
         signed_q <= req_signed;
         wdata_q  <= req_wdata[15:0];
      end
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the synchronous single-port data memory (1-cycle read latency, word addressed, read-before-write).
- Accepts CPU byte-addressed LDR/LDRB/LDRH/LDRSB/LDRSH/STR/STRB/STRH requests over a valid/ready handshake.
- Produces the memory's word address, write enable and write data.
- Handles sub-word stores by read-modify-write, and performs lane extraction and sign/zero extension on loads.

Parameters:
- data_width, 32, memory word width; fixed at 32.
- data_words, 512, number of memory words.
- data_addr_width, $clog2(data_words), memory word-address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected, with resp_valid.
- mem_we  out  1  to memory write enable.
- mem_addr  out  data_addr_width  to memory word address.
- mem_wd  out  32  to memory write data.
- mem_rd  in  32  from memory; valid the cycle after an address is presented.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Reset asserted mid-operation aborts the access with no memory write. A pending RMW write is dropped.
- States: IDLE, LD_WAIT, RMW, RESP. Accept = req_valid & req_ready.
- req_ready=1 only in IDLE with rst_n high.
- In IDLE, mem_addr = req_addr[data_addr_width+1:2] combinationally. In every other state, mem_addr comes from the held address register.
- Error check on accept: any of the following sets an error.
  - req_size=11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - req_addr >= 4*data_words.
- Error handling: no memory write; next state RESP with resp_err=1.
- Word store: mem_we = req_valid & req_we & size=10 & no error, mem_wd = req_wdata, both combinational in IDLE. The memory writes at the accept edge; next state RESP.
- Load: next state LD_WAIT. In LD_WAIT, mem_rd holds the word.
  - Extract the lane: byte lane = addr[1:0], half lane = addr[1], little-endian.
  - Zero- or sign-extend per req_signed; req_signed is ignored for word loads.
  - Register the result into resp_rdata; next state RESP.
- Sub-word store: the accept edge performs the memory read; next state RMW.
  - In RMW: mem_we=1, mem_addr = held address, mem_wd = mem_rd with the selected byte/half lane replaced by held wdata[7:0]/[15:0].
  - The write occurs at the RMW exit edge; next state RESP.
- RESP: resp_valid=1 for exactly this cycle; next state IDLE.
- resp_rdata and resp_err are held until the next RESP and are cleared to 0 on store or error responses.
- Latency accept-to-resp_valid: word store 1, error 1, load 2, sub-word store 2 cycles. Next request can be accepted the cycle after RESP.
- mem_we is never asserted outside IDLE word-store or RMW.
- req inputs are ignored when req_ready=0; no queuing.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum.
  - Error-check function.
- Sub-module lsu_lane_align (combinational):
  - Load extract/extend: inputs word, addr[1:0], size, signed.
  - Store merge: inputs old word, new data, addr[1:0], size.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem_we pulses at accept with mem_addr=4; load resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err=0.
- Memory word 4 = 0x80FF7F01; LDRSB 0x13 -> 0xFFFFFF80; LDRB 0x13 -> 0x00000080; LDRSH 0x10 -> 0x00007F01; LDRSH 0x12 -> 0xFFFF80FF.
- STRB 0x11 data 0xAB over 0x11223344 -> single write of 0x1122AB44 in RMW cycle, resp_valid 2 cycles after accept; STRH 0x12 data 0xCAFE -> 0xCAFE3344.
- Halfword load at 0x01, word at 0x06, size 11, address 0x800 -> resp_err=1 after 1 cycle; mem_we never asserted; memory unchanged.
- Back-to-back req_valid held high -> req_ready low in LD_WAIT/RMW/RESP; each request accepted once; second accepted the cycle after RESP.
- rst_n low during RMW cycle -> mem_we drops immediately; target word unchanged; all outputs at reset values; first request after release is handled normally.
